rr_mux_arb: RTL and testbench

Parametrised N-channel arbitrating multiplexer with a registered output stage. It generalises the one-hot select mux: instead of an externally supplied select, it picks among N valid/ready request channels by round-robin (or fixed-priority) arbitration and presents one word per cycle on a single valid/ready output. It sits between multiple producers (e.g. load/store or writeback sources) and a single shared consumer port, giving one cycle of latency and full throughput.

---
 rtl/rr_mux_arb_if.sv | 35 +++
 rtl/rr_mux_arb.sv | 151 +++++++++++++++
 tb/tb_rr_mux_arb.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_arb_if.sv
// rr_mux_arb_if -- bus bundle for the arbitrating multiplexer.
//   in_valid  [N]        per-channel request (producer -> arbiter)
//   in_data   [N*WIDTH]  channel i word at [i*WIDTH +: WIDTH]
//   in_ready  [N]        per-channel accept (arbiter -> producer), at most one hot
//   out_valid            output register holds a word
//   out_data  [WIDTH]    held word
//   out_ch    [IDX_W]    channel the held word came from
//   grant_oh  [N]        one-hot of out_ch, zero while out_valid=0
//   out_ready            consumer accepts the held word
// master: producers/consumer side; slave: the arbiter.
interface rr_mux_arb_if #(
  parameter int N     = 8,
  parameter int WIDTH = 16
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [IDX_W-1:0]   out_ch;
  logic [N-1:0]       grant_oh;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch, grant_oh
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch, grant_oh
  );
endinterface

// File: rtl/rr_mux_arb.sv
// rr_mux_arb -- N-channel arbitrating mux with a registered output stage.
// Picks one requesting channel per cycle (round-robin from a rotating
// pointer, or fixed lowest-index priority) and loads its word into a
// single valid/ready output register. One cycle latency, full throughput.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_mux_arb_if.slave (in_valid/in_data/in_ready,
//          out_valid/out_data/out_ch/grant_oh/out_ready)

// Per-channel lane: accept decision and gated data for the OR-mux.
//   valid_i/data_i  channel request and word
//   win_i           arbitration winner index
//   can_load_i      output register can take a word this cycle
//   ready_o         accept strobe for this channel
//   data_o          data_i when accepted, otherwise zero
module rr_mux_arb_lane #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 3,
  parameter int LANE  = 0
) (
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [IDX_W-1:0] win_i,
  input  logic             can_load_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o
);
  // win_i is the first requesting channel, so a match with valid_i
  // implies this lane is the unique winner.
  assign ready_o = can_load_i & valid_i & (win_i == IDX_W'(LANE));
  assign data_o  = data_i & {WIDTH{ready_o}};
endmodule

module rr_mux_arb #(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter bit RR    = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  rr_mux_arb_if.slave bus
);
  localparam int             IDX_W = $clog2(N);
  localparam logic [IDX_W:0] N_W   = (IDX_W+1)'(N);

  logic                      out_valid_q, out_valid_d;
  logic [WIDTH-1:0]          out_data_q, out_data_d;
  logic [IDX_W-1:0]          out_ch_q, out_ch_d;
  logic [N-1:0]              grant_q, grant_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;

  logic                      can_load;
  logic                      found;
  logic [IDX_W-1:0]          win;
  logic [IDX_W:0]            cand;
  logic [N-1:0]              ready;
  logic [N-1:0][WIDTH-1:0]   lane_data;
  logic [WIDTH-1:0]          mux_data;
  logic                      xfer;

  // Gating with rst_n keeps every in_ready low while reset is held.
  assign can_load = rst_n & (~out_valid_q | bus.out_ready);

  // Winner search. In round-robin mode the scan starts at ptr and wraps
  // modulo N; ptr < N so one conditional subtract is enough, and indices
  // >= N are never formed even when N is not a power of two.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      if (RR) begin
        cand = {1'b0, ptr_q} + (IDX_W+1)'(off);
        if (cand >= N_W) cand = cand - N_W;
      end else begin
        cand = (IDX_W+1)'(off);
      end
      if (!found && bus.in_valid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    rr_mux_arb_lane #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W),
      .LANE  (i)
    ) u_lane (
      .valid_i    (bus.in_valid[i]),
      .data_i     (bus.in_data[i*WIDTH +: WIDTH]),
      .win_i      (win),
      .can_load_i (can_load),
      .ready_o    (ready[i]),
      .data_o     (lane_data[i])
    );
  end

  // At most one lane is non-zero, so an OR-tree is the mux.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++) mux_data = mux_data | lane_data[i];
  end

  assign xfer         = |ready;
  assign bus.in_ready = ready;

  // A load takes priority over a drain, which gives replace-in-place on
  // simultaneous drain and load (no bubble).
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_ch_d    = win;
      grant_d     = ready;
      if (RR) ptr_d = (win == IDX_W'(N-1)) ? '0 : win + IDX_W'(1);
    end else if (bus.out_ready) begin
      // data and channel are left as-is on drain
      out_valid_d = 1'b0;
      grant_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      grant_q     <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.grant_oh  = grant_q;
endmodule

// File: tb/tb_rr_mux_arb.sv
// Scoreboard bench for rr_mux_arb. Three instances share clock/reset:
//   d0: N=8 WIDTH=16 round-robin, d1: N=8 WIDTH=16 fixed priority,
//   d2: N=5 WIDTH=8 round-robin.
// The stimulus process drives inputs, runs a reference arbiter and pushes
// each expected accepted word into a per-instance FIFO; a monitor process
// compares the presented output against the FIFO head and pops on out_ready.
module tb_rr_mux_arb;
  localparam int ND = 3;
  localparam int P_ALL = 0, P_SPARSE = 1, P_FP = 2, P_BP = 3,
                 P_RAND = 4, P_STALL = 5, P_IDLE = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          NN  [ND] = '{8, 8, 5};
  int          RRV [ND] = '{1, 0, 1};
  logic [15:0] WM  [ND] = '{16'hFFFF, 16'hFFFF, 16'h00FF};

  rr_mux_arb_if #(.N(8), .WIDTH(16)) bus0 ();
  rr_mux_arb_if #(.N(8), .WIDTH(16)) bus1 ();
  rr_mux_arb_if #(.N(5), .WIDTH(8))  bus2 ();

  rr_mux_arb #(.WIDTH(16), .N(8), .RR(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus0));
  rr_mux_arb #(.WIDTH(16), .N(8), .RR(1'b0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(bus1));
  rr_mux_arb #(.WIDTH(8),  .N(5), .RR(1'b1)) u_n5 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // Stimulus variables, common 16-bit view for all instances
  logic [15:0] tv_valid [ND];
  logic [15:0] tv_data  [ND][16];
  logic        tv_ordy  [ND];

  // Observed outputs, widened
  logic        ov  [ND];
  logic [15:0] od  [ND];
  logic [3:0]  och [ND];
  logic [15:0] og  [ND];
  logic [15:0] ir  [ND];

  always_comb begin
    bus0.in_valid  = tv_valid[0][7:0];
    bus1.in_valid  = tv_valid[1][7:0];
    bus2.in_valid  = tv_valid[2][4:0];
    bus0.out_ready = tv_ordy[0];
    bus1.out_ready = tv_ordy[1];
    bus2.out_ready = tv_ordy[2];
    bus0.in_data   = '0;
    bus1.in_data   = '0;
    bus2.in_data   = '0;
    for (int i = 0; i < 8; i++) begin
      bus0.in_data[i*16 +: 16] = tv_data[0][i];
      bus1.in_data[i*16 +: 16] = tv_data[1][i];
    end
    for (int i = 0; i < 5; i++) bus2.in_data[i*8 +: 8] = tv_data[2][i][7:0];
  end

  always_comb begin
    ov[0]  = bus0.out_valid;           ov[1]  = bus1.out_valid;
    ov[2]  = bus2.out_valid;
    od[0]  = bus0.out_data;            od[1]  = bus1.out_data;
    od[2]  = {8'h00, bus2.out_data};
    och[0] = {1'b0, bus0.out_ch};      och[1] = {1'b0, bus1.out_ch};
    och[2] = {1'b0, bus2.out_ch};
    og[0]  = {8'h00, bus0.grant_oh};   og[1]  = {8'h00, bus1.grant_oh};
    og[2]  = {11'h000, bus2.grant_oh};
    ir[0]  = {8'h00, bus0.in_ready};   ir[1]  = {8'h00, bus1.in_ready};
    ir[2]  = {11'h000, bus2.in_ready};
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", nm, d, $time, act, exp);
    end
  endtask

  // Expected-word FIFOs (depth 8 is ample; at most two entries are live)
  int          fq_ch  [ND][8];
  logic [15:0] fq_dat [ND][8];
  int          fq_wr  [ND] = '{0, 0, 0};
  int          fq_rd  [ND] = '{0, 0, 0};

  // Reference model state
  int m_ptr  [ND] = '{0, 0, 0};
  bit m_hold [ND] = '{0, 0, 0};
  int acc    [ND] = '{-1, -1, -1};

  // Channel that should win: scan from ptr modulo n (round robin) or from 0.
  function automatic int ref_winner(input int n, input int rr, input int ptr, input logic [15:0] v);
    for (int k = 0; k < n; k++) begin
      int c;
      c = (rr != 0) ? (ptr + k) % n : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] nmask(input int n);
    return 16'((32'd1 << n) - 1);
  endfunction

  // Monitor: one sample per cycle, before the stimulus process updates the model.
  bit mon_en = 1'b0;
  int mcnt, mix;
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      for (int d = 0; d < ND; d++) begin
        mcnt = fq_wr[d] - fq_rd[d];
        chk("out_valid", d, {31'b0, ov[d]}, {31'b0, mcnt != 0});
        if (mcnt != 0) begin
          mix = fq_rd[d] % 8;
          chk("out_data", d, {16'h0, od[d]}, {16'h0, fq_dat[d][mix]});
          chk("out_ch",   d, {28'h0, och[d]}, 32'(fq_ch[d][mix]));
          chk("grant_oh", d, {16'h0, og[d]}, 32'd1 << fq_ch[d][mix]);
          if (tv_ordy[d]) fq_rd[d]++;
        end else begin
          chk("grant_idle", d, {16'h0, og[d]}, 32'd0);
        end
      end
    end
  end

  task automatic gen(input int d, input int ph, input int k);
    int n;
    n = NN[d];
    case (ph)
      P_ALL: begin
        tv_valid[d] = nmask(n);
        for (int i = 0; i < 16; i++) tv_data[d][i] = 16'h100 + 16'(i);
        tv_ordy[d] = 1'b1;
      end
      P_SPARSE: begin
        tv_valid[d] = 16'h0084 & nmask(n);
        for (int i = 0; i < 16; i++) tv_data[d][i] = 16'h200 + 16'(i);
        tv_ordy[d] = 1'b1;
      end
      P_FP: begin
        tv_valid[d] = (k < 6) ? 16'h0006 : 16'h0004;
        for (int i = 0; i < 16; i++) tv_data[d][i] = 16'h300 + 16'(i);
        tv_ordy[d] = 1'b1;
      end
      P_BP: begin
        if (k == 0) begin
          tv_valid[d]    = 16'h0010;
          tv_data[d][4]  = 16'hBEEF;
        end else begin
          tv_valid[d]    = (n > 5) ? 16'h0020 : 16'h0008;
          tv_data[d][(n > 5) ? 5 : 3] = 16'h5A5A;
        end
        tv_ordy[d] = (k == 0) || (k >= 6);
      end
      P_RAND, P_STALL: begin
        // a pending request is held with its data until accepted
        for (int i = 0; i < n; i++) begin
          if (!(tv_valid[d][i] && acc[d] != i)) begin
            tv_valid[d][i] = 1'($urandom % 2);
            tv_data[d][i]  = 16'($urandom);
          end
        end
        tv_ordy[d] = (ph == P_STALL) ? 1'b0 : ($urandom % 4 != 0);
      end
      default: begin
        tv_valid[d] = '0;
        tv_ordy[d]  = 1'b1;
      end
    endcase
  endtask

  task automatic model(input int d);
    int w;
    bit cl;
    logic [15:0] er;
    cl = !m_hold[d] || tv_ordy[d];
    w  = ref_winner(NN[d], RRV[d], m_ptr[d], tv_valid[d]);
    er = (cl && w >= 0) ? 16'(32'd1 << w) : 16'h0;
    chk("in_ready", d, {16'h0, ir[d]}, {16'h0, er});
    acc[d] = -1;
    if (er != 16'h0) begin
      fq_ch[d][fq_wr[d] % 8]  = w;
      fq_dat[d][fq_wr[d] % 8] = tv_data[d][w] & WM[d];
      fq_wr[d]++;
      m_hold[d] = 1'b1;
      if (RRV[d] != 0) m_ptr[d] = (w + 1) % NN[d];
      acc[d] = w;
    end else if (tv_ordy[d]) begin
      m_hold[d] = 1'b0;
    end
  endtask

  task automatic cycle(input int ph, input int k);
    @(negedge clk);
    for (int d = 0; d < ND; d++) gen(d, ph, k);
    #2;
    for (int d = 0; d < ND; d++) model(d);
  endtask

  task automatic chk_reset_state(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk({tag, "_out_valid"}, d, {31'b0, ov[d]}, 32'd0);
      chk({tag, "_out_data"},  d, {16'h0, od[d]}, 32'd0);
      chk({tag, "_out_ch"},    d, {28'h0, och[d]}, 32'd0);
      chk({tag, "_grant_oh"},  d, {16'h0, og[d]}, 32'd0);
      chk({tag, "_in_ready"},  d, {16'h0, ir[d]}, 32'd0);
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      tv_valid[d] = '0;
      tv_ordy[d]  = 1'b1;
      for (int i = 0; i < 16; i++) tv_data[d][i] = '0;
    end
    // Power-on reset with requests pending: nothing may be accepted
    #3;
    for (int d = 0; d < ND; d++) tv_valid[d] = nmask(NN[d]);
    #20;
    chk_reset_state("por");
    for (int d = 0; d < ND; d++) tv_valid[d] = '0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int k = 0; k < 12;  k++) cycle(P_ALL, k);
    for (int k = 0; k < 8;   k++) cycle(P_SPARSE, k);
    for (int k = 0; k < 10;  k++) cycle(P_FP, k);
    for (int k = 0; k < 10;  k++) cycle(P_BP, k);
    for (int k = 0; k < 400; k++) cycle(P_RAND, k);

    // Reset in the middle of a stall: held words are dropped at once
    for (int k = 0; k < 4; k++) cycle(P_STALL, k);
    for (int d = 0; d < ND; d++) tv_valid[d] = nmask(NN[d]);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    for (int d = 0; d < ND; d++) begin
      fq_rd[d]  = fq_wr[d];
      m_hold[d] = 1'b0;
      m_ptr[d]  = 0;
      acc[d]    = -1;
    end
    @(negedge clk);
    #3;
    chk_reset_state("midrst_hold");
    for (int d = 0; d < ND; d++) begin
      tv_valid[d] = '0;
      tv_ordy[d]  = 1'b1;
    end
    rst_n = 1'b1;

    for (int k = 0; k < 200; k++) cycle(P_RAND, k);
    for (int k = 0; k < 4;   k++) cycle(P_IDLE, k);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
